dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 6, data-memory word address width; DATA_W, 16, data width; LOCK_MAX, 8, max consecutive locked debug grants while CPU waits.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 c_req  in  1  CPU access request; held until c_gnt.
REQ-005 c_we  in  1  CPU write (1) / read (0); c_addr  in  ADDR_W; c_wdata  in  DATA_W.
REQ-006 c_gnt  out  1  CPU request accepted this cycle.
REQ-007 c_rvalid  out  1  CPU read data valid; c_rdata  out  DATA_W.
REQ-008 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata: debug/loader port, same widths and meaning as CPU port.
REQ-009 d_lock  in  1  debug requests exclusive ownership across consecutive accesses.
REQ-010 m_en  out  1  memory access strobe; m_we  out  1; m_addr  out  ADDR_W; m_wdata  out  DATA_W.
REQ-011 m_rdata  in  DATA_W  memory read data, valid one cycle after m_en with m_we=0.
REQ-012 owner  out  2  FSM state for debug: 00 IDLE, 01 CPU_LAST, 10 DBG_LAST, 11 DBG_LOCK.

Function
REQ-013 At most one of c_gnt, d_gnt SHALL be high per cycle; a grant requires the matching req high.
REQ-014 Grants SHALL be combinational from req and FSM state (same-cycle acceptance); m_en = c_gnt | d_gnt.
REQ-015 m_we/m_addr/m_wdata SHALL be the granted port's c_/d_ fields; all m_* outputs zero when m_en low.
REQ-016 Arbitration in IDLE: both request -> CPU wins; single request -> that port wins.
REQ-017 In CPU_LAST with both requesting -> debug wins; in DBG_LAST with both requesting -> CPU wins (round-robin).
REQ-018 Transitions: CPU grant -> CPU_LAST; debug grant with d_lock=0 -> DBG_LAST; debug grant with d_lock=1 -> DBG_LOCK; no grant -> state held.
REQ-019 In DBG_LOCK only debug SHALL be granted while d_lock=1, regardless of c_req.
REQ-020 DBG_LOCK exit: d_lock=0 -> normal round-robin from DBG_LAST rules in the same cycle.
REQ-021 Starvation: 4-bit-minimum counter wait_cnt increments on each debug grant in DBG_LOCK while c_req=1; when wait_cnt == LOCK_MAX the next cycle with c_req=1 SHALL grant CPU and state -> CPU_LAST, clearing wait_cnt.
REQ-022 wait_cnt SHALL clear on any CPU grant and on leaving DBG_LOCK; it SHALL saturate, never wrap.
REQ-023 Read return: a granted read SHALL set a one-bit tag register (port ID) and a pending flag; next cycle the tagged port's rvalid = 1 and rdata = m_rdata.
REQ-024 Non-tagged port rdata SHALL hold its last returned value; rvalid is a single-cycle pulse per read.
REQ-025 Back-to-back reads (one per cycle, any mix of ports) SHALL each return exactly one cycle after grant with correct tag.
REQ-026 Writes SHALL produce no rvalid; a write followed next cycle by read of same address reads new data (memory write-first on edge).
REQ-027 Simultaneous d_lock rise and c_req in CPU_LAST: debug wins and enters DBG_LOCK.

Reset
REQ-028 On rst: state = IDLE, wait_cnt = 0, pending = 0, tag = 0, c_rdata = d_rdata = 0, c_rvalid = d_rvalid = 0.
REQ-029 While rst=1, c_gnt, d_gnt and m_en SHALL be 0 regardless of requests.
REQ-030 A read granted the cycle before rst asserts SHALL not produce rvalid in the reset cycle or after.

Verification
REQ-031 Reset, then c_req=1 d_req=1 reads addr 3 and 2 for 2 cycles -> cycle 0 c_gnt, cycle 1 d_gnt; c_rvalid cycle 1 with mem[3], d_rvalid cycle 2 with mem[2].
REQ-032 Debug write 16'hBEEF to addr 5, next cycle CPU read addr 5 -> c_rvalid one cycle later, c_rdata = 16'hBEEF.
REQ-033 d_lock=1, d_req=1 continuous, c_req=1, LOCK_MAX=8 -> 8 consecutive d_gnt, then one c_gnt, owner 11 -> 01.
REQ-034 d_lock drops mid-burst with c_req=1 -> c_gnt next arbitration cycle, wait_cnt = 0.
REQ-035 rst asserted cycle after CPU read grant -> no c_rvalid, all outputs at reset values, owner = 00.
REQ-036 Random req/we/addr for 10k cycles vs. reference model -> never both grants, no lost or duplicated rvalid, data match.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU port and a debug/loader port.
// It uses round-robin arbitration, a debug lock with a starvation guard, and tagged one-cycle read return.
module dmem_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        owner
);

  localparam int CNT_W = ($clog2(LOCK_MAX + 1) > 4) ? $clog2(LOCK_MAX + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CPU_LAST = 2'b01,
    ST_DBG_LAST = 2'b10,
    ST_DBG_LOCK = 2'b11
  } state_t;

  state_t            state_r, state_next_s;
  logic [CNT_W-1:0]  wait_cnt_r, wait_cnt_next_s;
  logic              c_gnt_s, d_gnt_s, starve_s, rd_s;
  logic              pending_r, tag_r;
  logic [DATA_W-1:0] c_rdata_r, d_rdata_r;

  assign starve_s = (wait_cnt_r == CNT_MAX);

  // Grant decision: same-cycle, from requests and the current owner state
  always_comb begin
    c_gnt_s = 1'b0;
    d_gnt_s = 1'b0;
    if (!rst) begin
      case (state_r)
        ST_IDLE, ST_DBG_LAST: begin
          if (c_req) c_gnt_s = 1'b1;
          else       d_gnt_s = d_req;
        end
        ST_CPU_LAST: begin
          if (d_req) d_gnt_s = 1'b1;
          else       c_gnt_s = c_req;
        end
        ST_DBG_LOCK: begin
          // A held lock shuts the CPU out until it has waited LOCK_MAX debug grants.
          if (d_lock && !(c_req && starve_s)) d_gnt_s = d_req;
          else if (c_req)                     c_gnt_s = 1'b1;
          else                                d_gnt_s = d_req;
        end
        default: begin
          c_gnt_s = 1'b0;
          d_gnt_s = 1'b0;
        end
      endcase
    end else begin
      c_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end
  end

  // Next owner state and starvation counter
  always_comb begin
    state_next_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    if (c_gnt_s) begin
      state_next_s    = ST_CPU_LAST;
      wait_cnt_next_s = '0;
    end else if (d_gnt_s) begin
      if (d_lock) begin
        state_next_s = ST_DBG_LOCK;
        if (state_r == ST_DBG_LOCK && c_req && !starve_s) wait_cnt_next_s = wait_cnt_r + CNT_W'(1);
        else                                              wait_cnt_next_s = wait_cnt_r;
      end else begin
        state_next_s    = ST_DBG_LAST;
        wait_cnt_next_s = '0;
      end
    end else begin
      state_next_s    = state_r;
      wait_cnt_next_s = wait_cnt_r;
    end
  end

  // Owner state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Memory request mux; everything is zero while no port is granted
  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt_s) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (d_gnt_s) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else begin
      m_we    = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
    end
  end

  assign rd_s = (c_gnt_s & ~c_we) | (d_gnt_s & ~d_we);

  // Read-return tracking: tag 0 = CPU, 1 = debug
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 1'b0;
      tag_r     <= 1'b0;
    end else begin
      pending_r <= rd_s;
      tag_r     <= rd_s ? d_gnt_s : tag_r;
    end
  end

  // The reset gate suppresses a return that was in flight when reset arrived
  assign c_rvalid = pending_r & ~tag_r & ~rst;
  assign d_rvalid = pending_r &  tag_r & ~rst;

  // Last-returned data holders
  always_ff @(posedge clk) begin
    if (rst) begin
      c_rdata_r <= '0;
      d_rdata_r <= '0;
    end else begin
      c_rdata_r <= c_rvalid ? m_rdata : c_rdata_r;
      d_rdata_r <= d_rvalid ? m_rdata : d_rdata_r;
    end
  end

  assign c_rdata = c_rvalid ? m_rdata : c_rdata_r;
  assign d_rdata = d_rvalid ? m_rdata : d_rdata_r;
  assign c_gnt   = c_gnt_s;
  assign d_gnt   = d_gnt_s;
  assign m_en    = c_gnt_s | d_gnt_s;
  assign owner   = state_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios, then random traffic.
// All traffic is checked against an ownership/scoreboard model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int LOCK_MAX = 8;

  logic clk, rst;
  logic c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0] owner;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: write-first, read data one cycle after the strobe
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] init_val [0:(1<<AW)-1];
  logic init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val[i];
      m_rdata <= '0;
    end else if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata <= mem[m_addr];
    end
  end

  // Reference model: who was served last, lock status, and how long the CPU has waited
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int  m_last;      // 0 nobody yet, 1 CPU, 2 debug
  bit  m_locked;
  int  m_waits;
  bit  pend_v, pend_dbg;
  logic [DW-1:0] pend_data, c_hold, d_hold;
  bit  eg_c, eg_d, exp_cv, exp_dv;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [1:0] exp_owner;
    #1;
    eg_c = 1'b0;
    eg_d = 1'b0;
    if (!rst) begin
      if (m_locked && d_lock) begin
        if (c_req && m_waits >= LOCK_MAX) eg_c = 1'b1;
        else eg_d = d_req;
      end else if (c_req && d_req) begin
        if (m_last == 1) eg_d = 1'b1;
        else eg_c = 1'b1;
      end else begin
        eg_c = c_req;
        eg_d = d_req;
      end
    end
    exp_cv = pend_v && !pend_dbg && !rst;
    exp_dv = pend_v &&  pend_dbg && !rst;
    exp_owner = m_locked ? 2'd3 : (m_last == 1) ? 2'd1 : (m_last == 2) ? 2'd2 : 2'd0;
    check("c_gnt", c_gnt, eg_c);
    check("d_gnt", d_gnt, eg_d);
    check("m_en", m_en, eg_c | eg_d);
    check("m_we", m_we, eg_c ? c_we : eg_d ? d_we : 1'b0);
    check("m_addr", m_addr, eg_c ? c_addr : eg_d ? d_addr : '0);
    check("m_wdata", m_wdata, eg_c ? c_wdata : eg_d ? d_wdata : '0);
    check("owner", owner, exp_owner);
    check("c_rvalid", c_rvalid, exp_cv);
    check("d_rvalid", d_rvalid, exp_dv);
    check("c_rdata", c_rdata, exp_cv ? pend_data : c_hold);
    check("d_rdata", d_rdata, exp_dv ? pend_data : d_hold);
  endtask

  task automatic advance();
    if (exp_cv) c_hold = pend_data;
    if (exp_dv) d_hold = pend_data;
    pend_v = 1'b0;
    if (rst) begin
      m_last = 0; m_locked = 1'b0; m_waits = 0;
      pend_dbg = 1'b0; c_hold = '0; d_hold = '0;
    end else if (eg_c) begin
      if (c_we) ref_mem[c_addr] = c_wdata;
      else begin pend_v = 1'b1; pend_dbg = 1'b0; pend_data = ref_mem[c_addr]; end
      m_last = 1; m_locked = 1'b0; m_waits = 0;
    end else if (eg_d) begin
      if (d_we) ref_mem[d_addr] = d_wdata;
      else begin pend_v = 1'b1; pend_dbg = 1'b1; pend_data = ref_mem[d_addr]; end
      if (d_lock) begin
        if (m_locked && c_req && m_waits < LOCK_MAX) m_waits++;
        m_locked = 1'b1;
      end else begin
        m_locked = 1'b0; m_waits = 0;
      end
      m_last = 2;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // Enter the lock, then let the CPU wait through LOCK_MAX debug grants
  task automatic lock_burst(input string tag);
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_lock = 1'b1; d_addr = 6'd11;
    sample(); check({tag, "_enter"}, d_gnt, 1'b1); advance();
    c_req = 1'b1; c_we = 1'b0; c_addr = 6'd7;
    for (int i = 0; i < LOCK_MAX; i++) begin
      sample();
      check({tag, "_dgnt"}, d_gnt, 1'b1);
      check({tag, "_own_lock"}, owner, 2'b11);
      advance();
    end
    sample(); check({tag, "_cgnt"}, c_gnt, 1'b1); check({tag, "_own11"}, owner, 2'b11); advance();
    c_req = 1'b0;
    sample(); check({tag, "_own01"}, owner, 2'b01); advance();
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      init_val[i] = DW'($urandom);
      ref_mem[i]  = init_val[i];
    end
    m_last = 0; m_locked = 1'b0; m_waits = 0;
    pend_v = 1'b0; pend_dbg = 1'b0; pend_data = '0; c_hold = '0; d_hold = '0;
    init_mem = 1'b1; rst = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    repeat (2) @(negedge clk);
    init_mem = 1'b0;

    // Requests under reset are ignored
    c_req = 1'b1; d_req = 1'b1;
    cycle();

    // Both read: CPU first, then debug, each data returning one cycle later
    rst = 1'b0; c_addr = 6'd3; d_addr = 6'd2;
    sample(); check("r31_c0", c_gnt, 1'b1); check("r31_addr0", m_addr, 6'd3); advance();
    sample(); check("r31_d1", d_gnt, 1'b1); check("r31_cv1", c_rvalid, 1'b1);
    check("r31_cdata", c_rdata, ref_mem[3]); advance();
    c_req = 1'b0; d_req = 1'b0;
    sample(); check("r31_dv2", d_rvalid, 1'b1); check("r31_ddata", d_rdata, ref_mem[2]); advance();

    // Debug write, then a CPU read of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd5; d_wdata = 16'hBEEF;
    sample(); check("r32_wr", m_wdata, 16'hBEEF); advance();
    d_req = 1'b0; d_we = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 6'd5;
    cycle();
    c_req = 1'b0;
    sample(); check("r32_cv", c_rvalid, 1'b1); check("r32_data", c_rdata, 16'hBEEF); advance();

    lock_burst("r33");

    // Lock released mid-burst: CPU wins at once, and a fresh burst gets the full budget
    c_req = 1'b1; c_addr = 6'd8; d_req = 1'b1; d_lock = 1'b1;
    repeat (3) cycle();
    d_lock = 1'b0;
    sample(); check("r34_cgnt", c_gnt, 1'b1); check("r34_dgnt", d_gnt, 1'b0); advance();
    lock_burst("r34_relock");

    // Reset right after a CPU read grant
    d_lock = 1'b0; d_req = 1'b0; c_req = 1'b1; c_we = 1'b0; c_addr = 6'd9;
    sample(); check("r35_gnt", c_gnt, 1'b1); advance();
    rst = 1'b1; d_req = 1'b1;
    sample(); check("r35_cv", c_rvalid, 1'b0); check("r35_men", m_en, 1'b0); advance();
    sample(); check("r35_own", owner, 2'b00); check("r35_cdata", c_rdata, 16'h0000); advance();
    rst = 1'b0; c_req = 1'b0; d_req = 1'b0;
    cycle();

    // Random traffic; requests are held until granted
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(499, 0) == 0);
      if (!c_req || eg_c) begin
        c_req = $urandom_range(1, 0) == 1; c_we = $urandom_range(1, 0) == 1;
        c_addr = AW'($urandom); c_wdata = DW'($urandom);
      end
      if (!d_req || eg_d) begin
        d_req = $urandom_range(1, 0) == 1; d_we = $urandom_range(1, 0) == 1;
        d_addr = AW'($urandom); d_wdata = DW'($urandom);
      end
      if ($urandom_range(15, 0) == 0) d_lock = ~d_lock;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
